// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end for the 16-bit pipelined core. Issues one word
//   read per cycle to a fixed-latency instruction memory, tracks the requests
//   in flight in a shift register, and captures the returning words in a small
//   return FIFO. Decode reads the FIFO head. Credit counting keeps the sum of
//   buffered and in-flight words at or below DEPTH, so a response always has
//   a free slot even while decode is stalled.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     When it is defined and the FIFO is empty, a returning word drives the
//     outputs in the same cycle it arrives. It is written into the FIFO only
//     if decode stalls that cycle.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   MEM_LATENCY  cycles from mem_rd to mem_rdata valid (1..4)
//   DEPTH        return FIFO entries (MEM_LATENCY+1..8)
//
// Ports
//   clk              clock, all state updates on posedge
//   reset            synchronous active-high reset
//   stall            decode cannot accept; hold the current output
//   flush            redirect; discard everything in flight and buffered
//   flush_pc         redirect target, sampled while flush=1
//   mem_rd           read strobe, at most one request per cycle
//   mem_raddr        word address for mem_rd
//   mem_rdata        read data, valid MEM_LATENCY cycles after mem_rd
//   out_valid        out_instruction/out_pc are meaningful
//   out_instruction  instruction to decode
//   out_pc           address of out_instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned DEPTH       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [15:0] flush_pc,
   output logic        mem_rd,
   output logic [15:0] mem_raddr,
   input  logic [15:0] mem_rdata,
   output logic        out_valid,
   output logic [15:0] out_instruction,
   output logic [15:0] out_pc
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned UW   = CW + 1;
   localparam int unsigned TAIL = MEM_LATENCY - 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } entry_t;

   logic [15:0]            pc_q, pc_d;
   logic [MEM_LATENCY-1:0] sr_vld_q, sr_vld_d;
   logic [15:0]            sr_addr_q [MEM_LATENCY];
   logic [15:0]            sr_addr_d [MEM_LATENCY];
   entry_t                 fifo_q [DEPTH];
   entry_t                 fifo_d [DEPTH];
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d, inflight_q, inflight_d;

   logic   tail_vld, fifo_empty, bypass, pop, fifo_pop, push, issue;
   logic [UW-1:0] used;
   entry_t head, tail_entry;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // Datapath: output selection, pop/push decisions and the issue credit check.
   // NOTE: every signal gets a default at the top of the always_comb so no path
   // leaves it unassigned; a missing default would infer a latch.
   always_comb begin
      tail_vld   = sr_vld_q[TAIL];
      tail_entry = '{pc: sr_addr_q[TAIL], instr: mem_rdata};
      fifo_empty = (count_q == '0);
      bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
      bypass     = fifo_empty & tail_vld;
`endif
      head      = bypass ? tail_entry : fifo_q[rd_ptr_q];
      out_valid = (bypass | ~fifo_empty) & ~flush & ~reset;
      pop       = out_valid & ~stall;
      fifo_pop  = pop & ~bypass;
      // A bypassed word needs storage only when decode refused it.
      push      = tail_vld & ~(bypass & ~stall);

      // Credits: words buffered plus words in flight, minus the one leaving.
      used  = UW'(count_q) + UW'(inflight_q) - UW'(pop);
      issue = ~reset & ~flush & (used < UW'(DEPTH));

      mem_rd          = issue;
      mem_raddr       = reset ? '0 : pc_q;
      out_pc          = out_valid ? head.pc    : '0;
      out_instruction = out_valid ? head.instr : '0;
   end

   // Next-state logic; flush wipes the pipe and the FIFO and redirects.
   always_comb begin
      pc_d        = issue ? pc_q + 16'd1 : pc_q;
      sr_vld_d    = sr_vld_q;
      sr_addr_d   = sr_addr_q;
      for (int i = MEM_LATENCY - 1; i >= 1; i--) begin
         sr_vld_d[i]  = sr_vld_q[i-1];
         sr_addr_d[i] = sr_addr_q[i-1];
      end
      sr_vld_d[0]  = issue;
      sr_addr_d[0] = pc_q;
      inflight_d   = inflight_q + CW'(issue) - CW'(tail_vld);

      fifo_d = fifo_q;
      if (push) fifo_d[wr_ptr_q] = tail_entry;
      wr_ptr_d = push     ? bump(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = fifo_pop ? bump(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(fifo_pop);

      if (flush) begin
         pc_d       = flush_pc;
         sr_vld_d   = '0;
         inflight_d = '0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every flop samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         sr_vld_q   <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         pc_q       <= pc_d;
         sr_vld_q   <= sr_vld_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // NOTE: payload storage has no reset; the valid bits and count guard every
   // read, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      sr_addr_q <= sr_addr_d;
      fifo_q    <= fifo_d;
   end

endmodule
